// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter
// Shares the single text-mode VRAM BRAM port between the HDMI scan-out
// fetcher (video) and the AXI4-Lite access path (bus).
//   - Active video: video wins conflicts. Blanking: bus wins conflicts.
//   - A saturating starvation counter forces one bus grant after STARVE_MAX
//     consecutive denied bus cycles, whatever the mode.
//   - Grants are combinational; BRAM controls are registered; read data
//     returns 3 cycles after the grant through a tagged pipeline.
// Optional feature: define VRAM_ARB_STATS_EN to build the video stall counter
// behind vid_stall_cnt; without it the port is tied to zero.
//
// Handshake (both requesters): req/addr/data are held stable until gnt is
// seen high; a transfer happens in any cycle with req && gnt; the next
// request may be presented in the following cycle. gnt never rises without
// req, and at most one gnt is high in a cycle.
module vram_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESET,
  input  logic                vid_active,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic                vid_gnt,
  output logic                vid_rvalid,
  output logic [DATA_W-1:0]   vid_rdata,
  input  logic                bus_req,
  input  logic                bus_we,
  input  logic [ADDR_W-1:0]   bus_addr,
  input  logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W/8-1:0] bus_wstrb,
  output logic                bus_gnt,
  output logic                bus_rvalid,
  output logic [DATA_W-1:0]   bus_rdata,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [15:0]         vid_stall_cnt
);

  localparam int         STRB_W     = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic       OWN_VID    = 1'b0;
  localparam logic       OWN_BUS    = 1'b1;

  // Tags are {is_read, owner}; is_read=0 marks an empty slot or a write.
  logic [3:0]        starve_q, starve_d;
  logic              ram_en_q, ram_en_d;
  logic [STRB_W-1:0] ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [1:0]        tag1_q, tag1_d;
  logic [1:0]        tag2_q;
  logic              vid_rvalid_q, vid_rvalid_d;
  logic              bus_rvalid_q, bus_rvalid_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
  logic [DATA_W-1:0] bus_rdata_q, bus_rdata_d;
  logic              vid_win, bus_win;

  // Arbitration: mode from vid_active this cycle, starvation overrides it
  always_comb begin
    bus_win = 1'b0;
    vid_win = 1'b0;
    if (!S_AXI_ARESET) begin
      bus_win = bus_req && (!vid_req || !vid_active || (starve_q == STARVE_LIM));
      vid_win = vid_req && !bus_win;
    end
  end

  assign vid_gnt = vid_win;
  assign bus_gnt = bus_win;

  // Next state: starvation count, BRAM issue stage, tag pipe, read return
  always_comb begin
    starve_d = 4'd0;
    if (bus_req && !bus_win) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
    end

    ram_en_d    = vid_win || bus_win;
    ram_we_d    = '0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    tag1_d      = 2'b00;
    if (bus_win) begin
      ram_addr_d  = bus_addr;
      ram_wdata_d = bus_wdata;
      if (bus_we) begin
        ram_we_d = bus_wstrb;
      end
      tag1_d = {!bus_we, OWN_BUS};
    end else if (vid_win) begin
      ram_addr_d = vid_addr;
      tag1_d     = {1'b1, OWN_VID};
    end

    // tag2_q lines up with ram_rdata (one cycle after ram_en)
    vid_rvalid_d = (tag2_q == {1'b1, OWN_VID});
    bus_rvalid_d = (tag2_q == {1'b1, OWN_BUS});
    vid_rdata_d  = vid_rvalid_d ? ram_rdata : vid_rdata_q;
    bus_rdata_d  = bus_rvalid_d ? ram_rdata : bus_rdata_q;
  end

  // State registers; reset discards anything in flight
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      starve_q     <= 4'd0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      tag1_q       <= 2'b00;
      tag2_q       <= 2'b00;
      vid_rvalid_q <= 1'b0;
      bus_rvalid_q <= 1'b0;
      vid_rdata_q  <= '0;
      bus_rdata_q  <= '0;
    end else begin
      starve_q     <= starve_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag1_q;
      vid_rvalid_q <= vid_rvalid_d;
      bus_rvalid_q <= bus_rvalid_d;
      vid_rdata_q  <= vid_rdata_d;
      bus_rdata_q  <= bus_rdata_d;
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign vid_rvalid = vid_rvalid_q;
  assign bus_rvalid = bus_rvalid_q;
  assign vid_rdata  = vid_rdata_q;
  assign bus_rdata  = bus_rdata_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of cycles where video asked but was not granted
  always_comb begin
    stall_d = stall_q;
    if (vid_req && !vid_win && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register, cleared only by reset
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign vid_stall_cnt = stall_q;
`else
  assign vid_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter
// Directed steps from the test plan followed by a randomized phase, checked
// against a transaction-level reference: a mirror of VRAM contents, a queue
// of expected read returns keyed by due cycle, and the priority rules.
module tb_vram_port_arbiter;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              vid_active, vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt, vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              bus_req, bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_gnt, bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [15:0]       vid_stall_cnt;

  vram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .vid_active(vid_active),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .vid_stall_cnt(vid_stall_cnt)
  );

  function automatic logic [31:0] init_val(int i);
    if (i == 5) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  // ---------------- BRAM model (read-first, 1-cycle latency) ----------------
  logic [31:0] bram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << ADDR_W); i++) bram[i] <= init_val(i);
      ram_rdata <= '0;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) bram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_rdata <= bram[ram_addr];
    end
  end

  // ---------------- scoreboard / reference ----------------
  typedef struct {
    int          due;
    logic        owner;   // 0 = video, 1 = bus
    logic [31:0] data;
  } ret_t;

  ret_t        exp_q[$];
  logic [31:0] mirror [0:(1<<ADDR_W)-1];
  int          vecs = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          m_starve = 0;
  logic [15:0] m_stall = 16'd0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [31:0] m_vdata = '0, m_bdata = '0;
  logic        last_ev = 1'b0, last_eb = 1'b0;
  int          n_vid_gnt = 0, n_bus_gnt = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) mirror[i] = init_val(i);
    m_starve = 0;
    m_stall  = 16'd0;
    m_addr   = '0;
    m_vdata  = '0;
    m_bdata  = '0;
    last_ev  = 1'b0;
    last_eb  = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_vid_gnt",    32'(vid_gnt), 32'd0);
    chk("rst_bus_gnt",    32'(bus_gnt), 32'd0);
    chk("rst_ram_en",     32'(ram_en), 32'd0);
    chk("rst_ram_we",     32'(ram_we), 32'd0);
    chk("rst_ram_addr",   32'(ram_addr), 32'd0);
    chk("rst_ram_wdata",  ram_wdata, 32'd0);
    chk("rst_vid_rvalid", 32'(vid_rvalid), 32'd0);
    chk("rst_bus_rvalid", 32'(bus_rvalid), 32'd0);
    chk("rst_vid_rdata",  vid_rdata, 32'd0);
    chk("rst_bus_rdata",  bus_rdata, 32'd0);
    chk("rst_stall_cnt",  32'(vid_stall_cnt), 32'd0);
  endtask

  task automatic set_idle();
    vid_req   = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_wstrb = 4'd0;
  endtask

  // One clock cycle: called just after a negedge with inputs applied.
  // Checks grants, advances the reference, checks registered outputs.
  task automatic tick();
    logic ev, eb, e_en;
    logic [3:0] e_we;
    logic [31:0] e_wd;
    logic e_vv, e_bv;
    logic [15:0] e_stall;
    ret_t r;
    #1;
    eb = bus_req && (!vid_req || !vid_active || (m_starve >= STARVE_MAX));
    ev = vid_req && !eb;
    chk("vid_gnt", 32'(vid_gnt), 32'(ev));
    chk("bus_gnt", 32'(bus_gnt), 32'(eb));
    if (vid_gnt) n_vid_gnt++;
    if (bus_gnt) n_bus_gnt++;

    if (bus_req && !eb) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
    else m_starve = 0;
    if (vid_req && !ev && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;

    e_we = 4'd0;
    e_wd = bus_wdata;
    if (eb) begin
      m_addr = bus_addr;
      if (bus_we) begin
        e_we = bus_wstrb;
        for (int b = 0; b < 4; b++)
          if (bus_wstrb[b]) mirror[bus_addr][b*8 +: 8] = bus_wdata[b*8 +: 8];
      end else begin
        exp_q.push_back('{cyc + 3, 1'b1, mirror[bus_addr]});
      end
    end else if (ev) begin
      m_addr = vid_addr;
      exp_q.push_back('{cyc + 3, 1'b0, mirror[vid_addr]});
    end
    e_en    = ev || eb;
    last_ev = ev;
    last_eb = eb;

    @(posedge clk);
    cyc++;
    #1;
    chk("ram_en",   32'(ram_en), 32'(e_en));
    chk("ram_we",   32'(ram_we), 32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(m_addr));
    if (eb) chk("ram_wdata", ram_wdata, e_wd);

    e_vv = 1'b0;
    e_bv = 1'b0;
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      if (r.owner) begin e_bv = 1'b1; m_bdata = r.data; end
      else         begin e_vv = 1'b1; m_vdata = r.data; end
    end
    chk("vid_rvalid", 32'(vid_rvalid), 32'(e_vv));
    chk("bus_rvalid", 32'(bus_rvalid), 32'(e_bv));
    chk("vid_rdata",  vid_rdata, m_vdata);
    chk("bus_rdata",  bus_rdata, m_bdata);
`ifdef VRAM_ARB_STATS_EN
    e_stall = m_stall;
`else
    e_stall = 16'd0;
`endif
    chk("vid_stall_cnt", 32'(vid_stall_cnt), 32'(e_stall));
    @(negedge clk);
  endtask

  task automatic idle(int n);
    set_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst        = 1'b1;
    vid_active = 1'b1;
    vid_addr   = '0;
    bus_addr   = '0;
    bus_wdata  = '0;
    set_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vid_req = 1'b1;
    bus_req = 1'b1;
    #1;
    chk_reset_outputs();
    set_idle();
    @(negedge clk);
    rst = 1'b0;

    // Single video read of the DEADBEEF word
    vid_req = 1'b1; vid_addr = 10'h005;
    tick();
    idle(3);
    chk("vid_read_deadbeef", vid_rdata, 32'hDEADBEEF);

    // Partial-strobe bus write, then read back
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 10'h010;
    bus_wdata = 32'h11223344; bus_wstrb = 4'b0101;
    tick();
    idle(1);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 10'h010;
    tick();
    idle(3);
    chk("wstrb_merge", bus_rdata, (init_val(16) & 32'hFF00FF00) | 32'h00220044);

    // Zero-strobe write: granted, ram_en=1, ram_we=0
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 10'h011;
    bus_wdata = 32'hFFFFFFFF; bus_wstrb = 4'b0000;
    tick();
    idle(2);

    // Continuous conflict during active video: 4 video, 1 bus, repeating
    n_vid_gnt = 0; n_bus_gnt = 0;
    vid_active = 1'b1;
    vid_req = 1'b1; vid_addr = 10'h040;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 10'h080;
    for (int i = 0; i < 15; i++) tick();
    chk("starve_vid_grants", 32'(n_vid_gnt), 32'd12);
    chk("starve_bus_grants", 32'(n_bus_gnt), 32'd3);
    idle(3);

    // Same conflict during blanking: bus every cycle
    n_vid_gnt = 0; n_bus_gnt = 0;
    vid_active = 1'b0;
    vid_req = 1'b1; vid_addr = 10'h041;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 10'h081;
    for (int i = 0; i < 8; i++) tick();
    chk("blank_vid_grants", 32'(n_vid_gnt), 32'd0);
    chk("blank_bus_grants", 32'(n_bus_gnt), 32'd8);
    idle(3);

    // Back-to-back reads vid, bus, vid
    vid_active = 1'b1;
    vid_req = 1'b1; vid_addr = 10'h020; tick();
    vid_req = 1'b0; bus_req = 1'b1; bus_we = 1'b0; bus_addr = 10'h021; tick();
    bus_req = 1'b0; vid_req = 1'b1; vid_addr = 10'h022; tick();
    idle(4);

    // Reset one cycle after a read grant: nothing comes back
    vid_req = 1'b1; vid_addr = 10'h030;
    tick();
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(6);

    // Randomized traffic honouring the hold-until-grant rule
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) vid_active = ~vid_active;
      if (!vid_req || last_ev) begin
        vid_req  = ($urandom_range(0, 2) != 0);
        vid_addr = ADDR_W'($urandom_range(0, 31));
      end
      if (!bus_req || last_eb) begin
        bus_req   = ($urandom_range(0, 1) != 0);
        bus_we    = ($urandom_range(0, 1) != 0);
        bus_addr  = ADDR_W'($urandom_range(0, 31));
        bus_wdata = $urandom;
        bus_wstrb = 4'($urandom_range(0, 15));
      end
      tick();
    end
    idle(4);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Arbitrates the single port of the text-mode VRAM block RAM between two requesters: the HDMI scan-out fetcher (video) and the AXI4-Lite slave register/VRAM access path (bus). It sits between the AXI slave's user logic and the BRAM. Video normally wins, but a bounded starvation counter guarantees bus progress. During blanking, priority flips to the bus. Read data is returned through a tagged 3-cycle pipeline.

## Interface
- ADDR_W, 10, VRAM word address width
- DATA_W, 32, VRAM word width; must be a multiple of 8
- STARVE_MAX, 4, consecutive denied cycles after which the bus is forced through; range 1..15

- S_AXI_ACLK  in  1  sole clock, rising edge
- S_AXI_ARESET  in  1  asynchronous, active-high reset
- vid_active  in  1  1 = active video region, 0 = blanking
- vid_req  in  1  video read request
- vid_addr  in  ADDR_W  video read address
- vid_gnt  out  1  video request accepted this cycle (combinational)
- vid_rvalid  out  1  video read data valid
- vid_rdata  out  DATA_W  video read data
- bus_req  in  1  bus request
- bus_we  in  1  1 = write, 0 = read
- bus_addr  in  ADDR_W  bus address
- bus_wdata  in  DATA_W  bus write data
- bus_wstrb  in  DATA_W/8  bus byte enables
- bus_gnt  out  1  bus request accepted this cycle (combinational)
- bus_rvalid  out  1  bus read data valid
- bus_rdata  out  DATA_W  bus read data
- ram_en  out  1  BRAM enable (registered)
- ram_we  out  DATA_W/8  BRAM byte write enables (registered)
- ram_addr  out  ADDR_W  BRAM address (registered)
- ram_wdata  out  DATA_W  BRAM write data (registered)
- ram_rdata  in  DATA_W  BRAM read data; valid one cycle after ram_en
- vid_stall_cnt  out  16  video stall statistic (see Configuration)

## Operation
- Handshake: a requester holds req, address, and data stable until it sees gnt high. A transfer occurs in a cycle where req and gnt are both high. The requester may present the next request in the following cycle. gnt is never high without req. At most one gnt is high per cycle.
- Priority mode is selected combinationally by vid_active:
  - VID_PRI (vid_active=1): video wins on conflict.
  - BUS_PRI (vid_active=0): bus wins on conflict.
  - A lone requester always wins.
- Starvation counter `starve` (4 bits):
  - Increments on every cycle with bus_req=1 and bus_gnt=0.
  - Clears on bus_gnt, or when bus_req=0.
  - When starve == STARVE_MAX, bus wins regardless of mode.
- Issue: on a grant, the registered stage loads ram_en=1, ram_addr, ram_wdata, and ram_we.
  - ram_we = bus_wstrb for a bus write; ram_we = 0 for reads.
  - With no grant, ram_en=0 and ram_we=0; ram_addr and ram_wdata hold their values.
- Read return: a 2-bit tag {is_read, owner} is pipelined alongside each request. Data from ram_rdata is registered into the owner's rdata, and that owner's rvalid pulses for exactly one cycle.
  - Bus writes produce no rvalid; bus_gnt is their completion.
  - A write with bus_wstrb=0 is still granted, with ram_en=1 and ram_we=0.
- Each rdata output holds its last value until that owner's next rvalid.

## Timing
- Grant decided in cycle N → ram_en/ram_addr valid in N+1 → ram_rdata valid in N+2 → rvalid/rdata valid in N+3. Read latency is 3 cycles from gnt.
- Throughput: one access per cycle, fully pipelined. Back-to-back reads return in order.
- Reset value of every output:
  - ram_en, ram_we, ram_addr, ram_wdata: 0
  - vid_rvalid, bus_rvalid, vid_rdata, bus_rdata: 0
  - vid_stall_cnt: 0
  - starve and the tag pipeline: cleared
  - vid_gnt and bus_gnt are 0 while S_AXI_ARESET=1.
- Reset mid-operation: in-flight reads are discarded and never produce rvalid after reset deasserts.
- vid_active may toggle in any cycle. The mode applies to the arbitration in that same cycle; already-granted transfers are unaffected.
- starve saturates at STARVE_MAX and never wraps.

## Configuration
- VRAM_ARB_STATS_EN defined:
  - vid_stall_cnt counts cycles with vid_req=1 and vid_gnt=0.
  - It saturates at 16'hFFFF and clears only on reset.
- VRAM_ARB_STATS_EN undefined: the port remains and is tied to 0; no counter logic is built.

## Test plan
- Single video read, addr 0x005, BRAM word 0xDEADBEEF, vid_active=1 → vid_gnt in cycle N, ram_en/addr 0x005 in N+1, vid_rvalid with 0xDEADBEEF in N+3, bus_rvalid stays 0.
- Bus write, addr 0x010, wdata 0x11223344, wstrb 4'b0101 → bus_gnt same cycle, ram_we=4'b0101 next cycle; a later read of 0x010 returns bytes 0 and 2 updated only; no bus_rvalid for the write.
- vid_req and bus_req both held high continuously, vid_active=1, STARVE_MAX=4 → four video grants, then one bus grant, repeating; no cycle with both gnt high.
- Same conflict with vid_active=0 → bus granted every cycle, vid_gnt=0; with VRAM_ARB_STATS_EN, vid_stall_cnt increments by 1 per cycle.
- Three back-to-back reads (vid, bus, vid) to distinct addresses → rvalids in consecutive cycles N+3..N+5, each data matching its address and routed to the correct owner.
- Assert S_AXI_ARESET in N+1 after a read grant in N → all outputs 0 immediately; no rvalid in N+3 or later after release.
